// File: rtl/cir_q_ctrl_if.sv
// Bundle of producer, completion, consumer and data-array signals for cir_q_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline and array.
interface cir_q_ctrl_if #(
   parameter int s_index  = 5,
   parameter int s_offset = 5
);
   localparam int W = 2 ** s_offset;

   logic               flush;
   logic               enq_valid;
   logic               enq_ready;
   logic [W-1:0]       enq_data;
   logic [s_index-1:0] enq_tag;
   logic               done_valid;
   logic [s_index-1:0] done_tag;
   logic               commit_valid;
   logic               commit_ready;
   logic [W-1:0]       commit_data;
   logic [s_index-1:0] commit_tag;
   logic [s_index:0]   count;
   logic               full;
   logic               empty;
   logic               arr_write;
   logic [s_index-1:0] arr_windex;
   logic [W-1:0]       arr_datain;
   logic [s_index-1:0] arr_commit_index;
   logic [W-1:0]       arr_dataout_commit;

   modport master (
      output flush, enq_valid, enq_data, done_valid, done_tag, commit_ready,
             arr_dataout_commit,
      input  enq_ready, enq_tag, commit_valid, commit_data, commit_tag, count,
             full, empty, arr_write, arr_windex, arr_datain, arr_commit_index
   );

   modport slave (
      input  flush, enq_valid, enq_data, done_valid, done_tag, commit_ready,
             arr_dataout_commit,
      output enq_ready, enq_tag, commit_valid, commit_data, commit_tag, count,
             full, empty, arr_write, arr_windex, arr_datain, arr_commit_index
   );
endinterface

// File: rtl/cir_q_ctrl.sv
// Head/tail controller for a circular queue: in-order commit of entries that may
// complete out of order. Payloads live in an external array; this block holds pointers and status.
module cir_q_ctrl #(
   parameter int s_index  = 5,
   parameter int s_offset = 5
) (
   input  logic        clk,
   input  logic        rst,
   cir_q_ctrl_if.slave q
);
   localparam int DEPTH = 2 ** s_index;
   localparam logic [s_index:0]   CNT_FULL = (s_index + 1)'(DEPTH);
   localparam logic [s_index:0]   CNT_ONE  = (s_index + 1)'(1);
   localparam logic [s_index-1:0] PTR_ONE  = s_index'(1);

   logic [s_index-1:0] head;
   logic [s_index-1:0] tail;
   logic [s_index:0]   count_r;
   logic [DEPTH-1:0]   valid_r;
   logic [DEPTH-1:0]   done_r;
   logic               full_w;
   logic               empty_w;
   logic               enq_fire;
   logic               commit_fire;

   assign full_w  = (count_r == CNT_FULL);
   assign empty_w = (count_r == '0);

   // A full queue refuses enqueues even while a commit frees a slot this cycle.
   assign q.enq_ready    = !full_w && !rst && !q.flush;
   assign q.commit_valid = !empty_w && done_r[head] && !q.flush && !rst;

   assign enq_fire    = q.enq_valid && q.enq_ready;
   assign commit_fire = q.commit_valid && q.commit_ready;

   assign q.arr_write        = enq_fire;
   assign q.arr_windex       = tail;
   assign q.arr_datain       = q.enq_data;
   assign q.arr_commit_index = head;
   assign q.commit_data      = q.arr_dataout_commit;
   assign q.commit_tag       = head;
   assign q.enq_tag          = tail;
   assign q.count            = count_r;
   assign q.full             = full_w;
   assign q.empty            = empty_w;

   // NOTE: status bits are plain flops, not a RAM, so they are cleared in one cycle on rst/flush;
   // the later commit assignment intentionally overrides a same-cycle done on the head entry.
   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         head    <= '0;
         tail    <= '0;
         count_r <= '0;
         valid_r <= '0;
         done_r  <= '0;
      end else begin
         if (enq_fire) begin
            valid_r[tail] <= 1'b1;
            done_r[tail]  <= 1'b0;
            tail          <= tail + PTR_ONE;
         end
         if (q.done_valid && valid_r[q.done_tag]) begin
            done_r[q.done_tag] <= 1'b1;
         end
         if (commit_fire) begin
            valid_r[head] <= 1'b0;
            done_r[head]  <= 1'b0;
            head          <= head + PTR_ONE;
         end
         unique case ({enq_fire, commit_fire})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cir_q_ctrl.sv
// Directed bench for cir_q_ctrl with a behavioural data array and an in-order commit scoreboard.
module tb_cir_q_ctrl;
   typedef struct {
      logic [4:0]  tag;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t exp_q[$];
   logic [4:0]  m_tail;
   logic [31:0] mem [32];

   cir_q_ctrl_if #(.s_index(5), .s_offset(5)) q ();

   cir_q_ctrl #(.s_index(5), .s_offset(5)) dut (
      .clk (clk),
      .rst (rst),
      .q   (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (q.arr_write) mem[q.arr_windex] <= q.arr_datain;
   end
   assign q.arr_dataout_commit = mem[q.arr_commit_index];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [31:0] d);
      q.enq_valid = 1'b1;
      q.enq_data  = d;
      #1;
      check("enq_ready", q.enq_ready, 1);
      check("arr_write", q.arr_write, 1);
      check("enq_tag", q.enq_tag, m_tail);
      check("arr_windex", q.arr_windex, m_tail);
      check("arr_datain", q.arr_datain, d);
      exp_q.push_back('{m_tail, d});
      m_tail = m_tail + 5'd1;
      step();
      q.enq_valid = 1'b0;
   endtask

   task automatic done(input logic [4:0] t);
      q.done_valid = 1'b1;
      q.done_tag   = t;
      step();
      q.done_valid = 1'b0;
   endtask

   task automatic commit_one(input int max_wait);
      exp_t e;
      int   n;
      n = 0;
      q.commit_ready = 1'b1;
      #1;
      while (!q.commit_valid && n < max_wait) begin
         step();
         #1;
         n++;
      end
      check("commit_valid", q.commit_valid, 1);
      e = exp_q.pop_front();
      check("commit_tag", q.commit_tag, e.tag);
      check("commit_data", q.commit_data, e.data);
      step();
      q.commit_ready = 1'b0;
   endtask

   initial begin
      exp_t e;
      checks = 0;
      errors = 0;
      m_tail = 5'd0;
      rst = 1'b1;
      q.flush = 1'b0;
      q.enq_valid = 1'b1;
      q.enq_data = 32'h55;
      q.done_valid = 1'b0;
      q.done_tag = 5'd0;
      q.commit_ready = 1'b0;

      // Reset held two cycles with a producer already offering data
      step();
      check("rst enq_ready", q.enq_ready, 0);
      check("rst arr_write", q.arr_write, 0);
      check("rst count", q.count, 0);
      check("rst commit_valid", q.commit_valid, 0);
      step();
      check("rst2 arr_write", q.arr_write, 0);
      rst = 1'b0;
      q.enq_valid = 1'b0;
      #1;
      check("post enq_ready", q.enq_ready, 1);
      check("post empty", q.empty, 1);
      check("post full", q.full, 0);
      check("post count", q.count, 0);
      check("post commit_valid", q.commit_valid, 0);
      check("post enq_tag", q.enq_tag, 0);
      check("post commit_tag", q.commit_tag, 0);

      // Fill to 32, then a rejected 33rd offer
      for (int i = 0; i < 32; i++) enq(32'h100 + i);
      #1;
      check("fill count", q.count, 32);
      check("fill full", q.full, 1);
      check("fill enq_ready", q.enq_ready, 0);
      q.enq_valid = 1'b1;
      q.enq_data  = 32'h999;
      #1;
      check("33rd arr_write", q.arr_write, 0);
      step();
      q.enq_valid = 1'b0;
      #1;
      check("33rd enq_tag", q.enq_tag, 0);
      check("33rd count", q.count, 32);

      // Full queue with a commit firing: no same-cycle slot reuse
      done(5'd0);
      q.enq_valid = 1'b1;
      q.enq_data = 32'hDEAD;
      q.commit_ready = 1'b1;
      #1;
      check("full+commit commit_valid", q.commit_valid, 1);
      check("full+commit enq_ready", q.enq_ready, 0);
      check("full+commit arr_write", q.arr_write, 0);
      e = exp_q.pop_front();
      check("full+commit tag", q.commit_tag, e.tag);
      check("full+commit data", q.commit_data, e.data);
      step();
      q.enq_valid = 1'b0;
      q.commit_ready = 1'b0;
      #1;
      check("after commit enq_ready", q.enq_ready, 1);
      check("after commit count", q.count, 31);
      for (int t = 1; t < 32; t++) done(5'(t));
      for (int i = 0; i < 31; i++) commit_one(0);
      #1;
      check("drain count", q.count, 0);
      check("drain empty", q.empty, 1);

      // Out-of-order completion, in-order commit
      for (int i = 0; i < 4; i++) enq(32'h300 + i);
      done(5'd3);
      #1;
      check("ooo after 3", q.commit_valid, 0);
      done(5'd1);
      done(5'd2);
      #1;
      check("ooo after 1,2", q.commit_valid, 0);
      q.done_valid = 1'b1;
      q.done_tag = 5'd0;
      q.commit_ready = 1'b1;
      #1;
      check("done+ready same cycle", q.commit_valid, 0);
      step();
      q.done_valid = 1'b0;
      for (int i = 0; i < 4; i++) commit_one(0);

      // Wrap-around: move head/tail to 20, then 20 entries straddling the wrap
      for (int i = 0; i < 16; i++) enq(32'h400 + i);
      for (int t = 4; t < 20; t++) done(5'(t));
      for (int i = 0; i < 16; i++) commit_one(0);
      for (int i = 0; i < 20; i++) enq(32'h500 + i);
      #1;
      check("wrap count", q.count, 20);
      check("wrap enq_tag", q.enq_tag, 8);
      for (int t = 20; t < 40; t++) done(5'(t % 32));
      for (int i = 0; i < 20; i++) commit_one(0);
      #1;
      check("wrap drained", q.count, 0);

      // Simultaneous enqueue and commit at count=5
      for (int i = 0; i < 5; i++) enq(32'h600 + i);
      done(5'd8);
      q.enq_valid = 1'b1;
      q.enq_data = 32'h6FF;
      q.commit_ready = 1'b1;
      #1;
      check("sim commit_valid", q.commit_valid, 1);
      check("sim enq_ready", q.enq_ready, 1);
      check("sim enq_tag", q.enq_tag, m_tail);
      e = exp_q.pop_front();
      check("sim commit_tag", q.commit_tag, e.tag);
      check("sim commit_data", q.commit_data, e.data);
      exp_q.push_back('{m_tail, 32'h6FF});
      m_tail = m_tail + 5'd1;
      step();
      q.enq_valid = 1'b0;
      q.commit_ready = 1'b0;
      #1;
      check("sim count", q.count, 5);

      // Done on an invalid tag leaves state alone
      done(5'd20);
      #1;
      check("bad done commit_valid", q.commit_valid, 0);
      check("bad done count", q.count, 5);
      check("bad done commit_tag", q.commit_tag, 9);
      check("bad done enq_tag", q.enq_tag, 14);
      for (int t = 9; t < 14; t++) done(5'(t));
      for (int i = 0; i < 5; i++) commit_one(0);

      // Flush with 10 entries, 3 done, and every other request active
      for (int i = 0; i < 10; i++) enq(32'h700 + i);
      done(5'd14);
      done(5'd15);
      done(5'd16);
      #1;
      check("pre-flush commit_valid", q.commit_valid, 1);
      q.flush = 1'b1;
      q.enq_valid = 1'b1;
      q.enq_data = 32'h7FF;
      q.commit_ready = 1'b1;
      q.done_valid = 1'b1;
      q.done_tag = 5'd17;
      #1;
      check("flush arr_write", q.arr_write, 0);
      check("flush commit_valid", q.commit_valid, 0);
      check("flush enq_ready", q.enq_ready, 0);
      step();
      q.flush = 1'b0;
      q.enq_valid = 1'b0;
      q.commit_ready = 1'b0;
      q.done_valid = 1'b0;
      #1;
      check("flush count", q.count, 0);
      check("flush empty", q.empty, 1);
      check("flush enq_tag", q.enq_tag, 0);
      check("flush commit_tag", q.commit_tag, 0);
      check("flush commit_valid after", q.commit_valid, 0);
      exp_q.delete();
      m_tail = 5'd0;
      enq(32'h800);
      done(5'd0);
      commit_one(2);
      #1;
      check("final count", q.count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
